// File: rtl/d_shift_pkg.sv
// Shared types and constants for the d_shift_reg register bank.
package d_shift_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/d_shift_ctrl.sv
// Burst controller for d_shift_reg: FSM, down-counter, busy/done and the
// per-cycle step enable with the direction/rotate it should use.
module d_shift_ctrl
  import d_shift_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             start,
  input  logic             shift,
  input  logic             dir,
  input  logic             rot,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             step,
  output logic             step_dir,
  output logic             step_rot
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_BURST) begin
      cnt_d = cnt_q - LEN_W'(1);
      if (cnt_q == LEN_W'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (start) begin
      // A zero-length burst completes immediately without touching q.
      if (len != '0) begin
        state_d = ST_BURST;
        cnt_d   = len;
        dir_d   = dir;
        rot_d   = rot;
      end else begin
        done_d = 1'b1;
      end
    end
    busy_d = (state_d == ST_BURST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_LEFT;
      rot_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    step     = 1'b0;
    step_dir = dir;
    step_rot = rot;
    if (!load) begin
      if (state_q == ST_BURST) begin
        step     = 1'b1;
        step_dir = dir_q;
        step_rot = rot_q;
      end else begin
        step = shift && !start;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/d_shift_reg.sv
// WIDTH-bit shift register with parallel load, single-step and counted burst
// shifting. Define D_SHIFT_REG_ROTATE_EN to add the rot port (rotate mode).
module d_shift_reg
  import d_shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               LEN_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             shift,
  input  logic             dir,
  input  logic             sin,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
`ifdef D_SHIFT_REG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             step, step_dir, step_rot;
  logic             rot_in;
  logic             out_bit, fill_bit;

`ifdef D_SHIFT_REG_ROTATE_EN
  assign rot_in = rot;
`else
  assign rot_in = 1'b0;
`endif

  d_shift_ctrl #(.LEN_W(LEN_W)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .start    (start),
    .shift    (shift),
    .dir      (dir),
    .rot      (rot_in),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .step     (step),
    .step_dir (step_dir),
    .step_rot (step_rot)
  );

  // In rotate mode the departing bit re-enters at the vacated end.
  assign out_bit  = (step_dir == DIR_LEFT) ? q_q[WIDTH-1] : q_q[0];
  assign fill_bit = step_rot ? out_bit : sin;

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    if (load) begin
      q_d = d;
    end else if (step) begin
      sout_d = out_bit;
      if (step_dir == DIR_LEFT) q_d = {q_q[WIDTH-2:0], fill_bit};
      else                      q_d = {fill_bit, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      sout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;

endmodule

// File: tb/tb_d_shift_reg.sv
// Directed self-checking bench for d_shift_reg (WIDTH=8); rotate cases are
// included when D_SHIFT_REG_ROTATE_EN is defined.
module tb_d_shift_reg;

  localparam int WIDTH = 8;
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst, load, shift, dir, sin, start, rot;
  logic [WIDTH-1:0] d;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] q;
  logic             sout, busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  d_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .load  (load),
    .shift (shift),
    .dir   (dir),
    .sin   (sin),
    .start (start),
    .len   (len),
`ifdef D_SHIFT_REG_ROTATE_EN
    .rot   (rot),
`endif
    .q     (q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one edge's worth of inputs, then sample #1 after the edge.
  task automatic applyStimulus(input logic r, input logic ld, input logic [WIDTH-1:0] dv,
                               input logic sh, input logic dr, input logic si,
                               input logic st, input logic [LEN_W-1:0] ln, input logic rt);
    rst = r; load = ld; d = dv; shift = sh; dir = dr; sin = si; start = st; len = ln; rot = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkAll(input string tag, input logic [7:0] eq, input logic es,
                          input logic eb, input logic ed);
    checkOutput({tag, ".q"},    32'(q),    32'(eq));
    checkOutput({tag, ".sout"}, 32'(sout), 32'(es));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(eb));
    checkOutput({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    applyStimulus(1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    checkAll("reset", 8'h00, 0, 0, 0);

    applyStimulus(0, 1, 8'hA5, 0, 0, 0, 0, 0, 0);
    checkAll("load", 8'hA5, 0, 0, 0);

    applyStimulus(0, 0, 8'h00, 1, 1, 1, 0, 0, 0);
    checkAll("shr", 8'hD2, 1, 0, 0);

    applyStimulus(0, 1, 8'hA5, 0, 0, 0, 0, 0, 0);
    checkAll("load_keep_sout", 8'hA5, 1, 0, 0);

    // Burst of 3 left shifts with sin=0.
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 1, 4'd3, 0);
    checkAll("b3_e0", 8'hA5, 1, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    checkAll("b3_e1", 8'h4A, 1, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    checkAll("b3_e2", 8'h94, 0, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    checkAll("b3_e3", 8'h28, 1, 0, 1);
    idle();
    checkAll("b3_after", 8'h28, 1, 0, 0);

    // Burst of 2 right shifts; start/shift/dir during BURST are ignored.
    applyStimulus(0, 0, 8'h00, 0, 1, 1, 1, 4'd2, 0);
    checkAll("b2_e0", 8'h28, 1, 1, 0);
    applyStimulus(0, 0, 8'h00, 1, 0, 1, 1, 4'd7, 0);
    checkAll("b2_e1", 8'h94, 0, 1, 0);
    applyStimulus(0, 0, 8'h00, 1, 0, 1, 1, 4'd7, 0);
    checkAll("b2_e2", 8'hCA, 0, 0, 1);
    idle();
    checkAll("b2_after", 8'hCA, 0, 0, 0);

    // Burst of 5 aborted by load on edge 2.
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 1, 4'd5, 0);
    checkAll("abort_e0", 8'hCA, 0, 1, 0);
    idle();
    checkAll("abort_e1", 8'h94, 1, 1, 0);
    applyStimulus(0, 1, 8'h3C, 0, 0, 0, 0, 0, 0);
    checkAll("abort_e2", 8'h3C, 1, 0, 0);
    idle();
    checkAll("abort_e3", 8'h3C, 1, 0, 0);

    applyStimulus(0, 0, 8'h00, 0, 0, 0, 1, 4'd0, 0);
    checkAll("len0", 8'h3C, 1, 0, 1);
    idle();
    checkAll("len0_after", 8'h3C, 1, 0, 0);

    // Reset in the middle of a burst.
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 1, 4'd4, 0);
    checkAll("rstb_e0", 8'h3C, 1, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 0, 0, 0);
    checkAll("rstb_e1", 8'h79, 0, 1, 0);
    applyStimulus(1, 0, 8'h00, 0, 0, 1, 0, 0, 0);
    checkAll("rstb_e2", 8'h00, 0, 0, 0);
    idle();
    checkAll("rstb_e3", 8'h00, 0, 0, 0);

    // load and start together: load wins, start dropped.
    applyStimulus(0, 1, 8'h55, 0, 0, 0, 1, 4'd3, 0);
    checkAll("ldst", 8'h55, 0, 0, 0);
    idle();
    checkAll("ldst_after", 8'h55, 0, 0, 0);

    // len > WIDTH: 9 right shifts of 0xFF fill with sin=0.
    applyStimulus(0, 1, 8'hFF, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 1, 4'd9, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    checkAll("len9_e8", 8'h00, 1, 1, 0);
    idle();
    checkAll("len9_e9", 8'h00, 0, 0, 1);

`ifdef D_SHIFT_REG_ROTATE_EN
    applyStimulus(0, 1, 8'h81, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0, 0, 1);
    checkAll("rotl", 8'h03, 1, 0, 0);
    applyStimulus(0, 1, 8'h81, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 1, 4'd8, 1);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    checkAll("rot8_e7", 8'hC0, 0, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    checkAll("rot8_e8", 8'h81, 1, 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
